aes128_key_schedule_ctrl: RTL

Iterative AES-128 key schedule controller. It accepts a cipher key over a valid/ready handshake and runs the expansion round by round through one shared key-expansion step with a runtime-selected rcon. It stores round keys 0..10 in an internal register file and serves them to the cipher core through a registered read port. It sits between the key-load interface and the encrypt/decrypt round datapaths, replacing ten unrolled expansion stages with one.

---
 rtl/aes128_key_schedule_ctrl_pkg.sv | 36 +++
 rtl/aes128_key_expansion_step.sv | 18 +
 rtl/aes128_key_schedule_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/aes128_key_schedule_ctrl_pkg.sv
// aes128_key_schedule_ctrl_pkg: AES-128 key schedule sizes, rcon constants and the S-box lookup.
package aes128_key_schedule_ctrl_pkg;
  localparam int AES128_KEY_SIZE = 128;
  localparam int AES_WORD_SIZE = 32;
  localparam int AES128_NUM_ROUNDS = 10;
  localparam logic [31:0] AES_RCON_01 = 32'h01000000;
  localparam logic [31:0] AES_RCON_02 = 32'h02000000;
  localparam logic [31:0] AES_RCON_03 = 32'h04000000;
  localparam logic [31:0] AES_RCON_04 = 32'h08000000;
  localparam logic [31:0] AES_RCON_05 = 32'h10000000;
  localparam logic [31:0] AES_RCON_06 = 32'h20000000;
  localparam logic [31:0] AES_RCON_07 = 32'h40000000;
  localparam logic [31:0] AES_RCON_08 = 32'h80000000;
  localparam logic [31:0] AES_RCON_09 = 32'h1b000000;
  localparam logic [31:0] AES_RCON_10 = 32'h36000000;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction
endpackage

// File: rtl/aes128_key_expansion_step.sv
// aes128_key_expansion_step: one combinational AES-128 key expansion round with a runtime rcon.
module aes128_key_expansion_step
  import aes128_key_schedule_ctrl_pkg::*;
(
  input  logic [AES128_KEY_SIZE-1:0] key,
  input  logic [AES_WORD_SIZE-1:0]   rcon,
  output logic [AES128_KEY_SIZE-1:0] new_key
);
  logic [AES_WORD_SIZE-1:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
  assign {w0, w1, w2, w3} = key;
  // SubWord(RotWord(w3)): the rotate is folded into the byte order of the lookups
  assign t = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]), aes_sbox(w3[7:0]), aes_sbox(w3[31:24])} ^ rcon;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign new_key = {n0, n1, n2, n3};
endmodule

// File: rtl/aes128_key_schedule_ctrl.sv
// aes128_key_schedule_ctrl: iterative AES-128 key expansion into an 11-entry round key file.
module aes128_key_schedule_ctrl
  import aes128_key_schedule_ctrl_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_valid,
  output logic                       key_ready,
  input  logic [AES128_KEY_SIZE-1:0] key,
  input  logic                       flush,
  output logic                       busy,
  output logic                       done,
  input  logic [3:0]                 rk_idx,
  output logic [AES128_KEY_SIZE-1:0] rk
);
  if (ROUNDS != AES128_NUM_ROUNDS) begin : g_bad_rounds
    $error("aes128_key_schedule_ctrl supports ROUNDS == 10 only");
  end
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;
  state_e state_q, state_d;
  logic [3:0] round_q, round_d;
  logic done_q, done_d;
  logic [AES128_KEY_SIZE-1:0] cur_key_q, cur_key_d, rk_q, rk_d, next_key;
  logic [AES128_KEY_SIZE-1:0] slot_q [AES128_NUM_ROUNDS+1];
  logic [AES128_KEY_SIZE-1:0] slot_d [AES128_NUM_ROUNDS+1];
  logic [AES_WORD_SIZE-1:0] rcon;
  logic accept;
  aes128_key_expansion_step u_step (.key(cur_key_q), .rcon(rcon), .new_key(next_key));
  always_comb begin
    case (round_q)
      4'd1:    rcon = AES_RCON_01;
      4'd2:    rcon = AES_RCON_02;
      4'd3:    rcon = AES_RCON_03;
      4'd4:    rcon = AES_RCON_04;
      4'd5:    rcon = AES_RCON_05;
      4'd6:    rcon = AES_RCON_06;
      4'd7:    rcon = AES_RCON_07;
      4'd8:    rcon = AES_RCON_08;
      4'd9:    rcon = AES_RCON_09;
      4'd10:   rcon = AES_RCON_10;
      default: rcon = '0;
    endcase
  end
  assign key_ready = (state_q != EXPAND) && !flush;
  assign accept = key_ready && key_valid;
  assign busy = state_q == EXPAND;
  assign done = done_q;
  assign rk = rk_q;
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    done_d = done_q;
    cur_key_d = cur_key_q;
    slot_d = slot_q;
    rk_d = (rk_idx <= 4'd10) ? slot_q[rk_idx] : '0;
    if (flush) begin
      state_d = IDLE;
      done_d = 1'b0;
      round_d = '0;
    end else if (accept) begin
      slot_d[0] = key;
      cur_key_d = key;
      round_d = 4'd1;
      state_d = EXPAND;
      done_d = 1'b0;
    end else if (state_q == EXPAND) begin
      slot_d[round_q] = next_key;
      cur_key_d = next_key;
      state_d = (round_q == 4'(ROUNDS)) ? READY : EXPAND;
      done_d = round_q == 4'(ROUNDS);
      round_d = (round_q == 4'(ROUNDS)) ? round_q : round_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      done_q <= 1'b0;
      cur_key_q <= '0;
      rk_q <= '0;
      slot_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q <= done_d;
      cur_key_q <= cur_key_d;
      rk_q <= rk_d;
      slot_q <= slot_d;
    end
  end
endmodule
